adt7420_temp_to_bcd: RTL
========================

Name: adt7420_temp_to_bcd

Overview:
Downstream consumer of the ADT7420 I2C reader's 16-bit raw temperature word. Converts the 13-bit two's-complement reading (0.0625 °C/LSB) into a sign flag, 3 integer BCD digits and 2 fraction BCD digits, using a multi-cycle double-dabble. Feeds the 7-segment scan stage over a valid/ready handshake, replacing the combinational divide/modulo path.

Parameters:
IN_W, 16, width of raw input word; temperature occupies bits [15:3], bits [2:0] are ignored.
TEMP_BITS, 13, width of the signed temperature field.

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
in_valid  in  1  raw word available
in_ready  out  1  block can accept a word (high only in IDLE)
temp_raw  in  16  raw ADT7420 register pair, MSB first
out_valid  out  1  result digits valid
out_ready  in  1  downstream consumed result
neg  out  1  1 = temperature below 0
int_bcd  out  12  {hundreds, tens, units}, 4 bits each
frac_bcd  out  8  {tenths, hundredths}, 4 bits each

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. Reset: state=IDLE, in_ready=1, out_valid=0, neg=0, int_bcd=0, frac_bcd=0. Reset mid-conversion aborts it; no result is emitted.
- FSM: IDLE -> PREP -> INT -> FRAC -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch temp_raw[15:3] and go to PREP.
- PREP (1 cycle): neg=t[12]; mag=neg ? -t : t, as a 13-bit unsigned value (max 4096). ip=mag[12:4] (9 bits, 0..256). fp=mag[3:0]*625 (14 bits, 0..9375). Clear the BCD scratch registers.
- INT (9 cycles): one double-dabble step per cycle on ip. Each step: add 3 to every nibble >=5, then shift left 1.
- FRAC (14 cycles): same procedure on fp into 4 scratch nibbles. Keep the top two nibbles as tenths and hundredths; the low two are discarded (truncation).
- Output registers neg/int_bcd/frac_bcd are written at the FRAC->DONE edge and held until the next conversion completes.
- DONE: out_valid=1. Stays until out_ready=1; that edge returns to IDLE and out_valid drops the next cycle.
- Latency: out_valid goes high exactly 24 clk edges after the accepting edge (1 PREP + 9 INT + 14 FRAC).
- in_ready=0 in PREP/INT/FRAC/DONE. No overlap: in_valid is ignored outside IDLE, and the upstream holds its word.
- Boundaries:
  - -0.0625 gives neg=1, 000.06.
  - Raw -4096 (13'h1000) gives mag 4096, neg=1, 256.00.
  - Zero gives neg=0, 000.00; there is never a negative zero.
- Cycle counters are 4 bits and reset to 0 on entry to INT and FRAC.

Optional Feature:
ADT7420_BCD_ROUND_EN
- Defined: round the 2-digit fraction half-up using the thousandths nibble (>=5 increments hundredths). For all 16 fraction values the hundredths never exceed 9, so no carry logic is needed. Latency unchanged (rounding happens at the FRAC->DONE edge).
- Undefined: truncate, as described above.

Decomposition:
- Package adt7420_pkg:
  - FSM state typedef (IDLE, PREP, INT, FRAC, DONE)
  - TEMP_BITS, FRAC_BITS=4, FRAC_SCALE=625, INT_STEPS=9, FRAC_STEPS=14, BCD_W=4
- Sub-module bcd_add3_shift: combinational single double-dabble step over N nibbles (parameter N). Instantiated twice, with N=3 for the integer path and N=4 for the fraction path.

Test Plan:
- temp_raw=16'h0C88 (+25.0625) -> 24 cycles later out_valid=1, neg=0, int_bcd=12'h025, frac_bcd=8'h06 (also 8'h06 with ROUND_EN).
- temp_raw=16'h0C18 (+24.1875) -> int_bcd=12'h024, frac_bcd=8'h18; with ADT7420_BCD_ROUND_EN frac_bcd=8'h19.
- temp_raw=16'hE480 (-55.0) -> neg=1, int_bcd=12'h055, frac_bcd=8'h00; temp_raw=16'hFFF8 -> neg=1, 000.06; temp_raw=16'h4B00 -> neg=0, 150.00.
- Backpressure: hold out_ready=0 for 100 cycles. out_valid and digits remain stable, in_ready=0, and a new in_valid is ignored. Pulse out_ready -> IDLE, in_ready=1 next cycle.
- Reset: assert rst during INT (cycle 5 after accept) -> next cycle out_valid=0, outputs 0, in_ready=1; a following conversion of 16'h0C88 yields 025.06.
- Sweep all 8192 13-bit codes against a reference model (sign, integer, truncated and rounded fraction). Check latency = 24 on every conversion.

Source files
------------

// File: rtl/adt7420_pkg.sv
// Shared types and constants for the ADT7420 temperature-to-BCD converter.
package adt7420_pkg;

  localparam int unsigned TEMP_BITS  = 13;
  localparam int unsigned FRAC_BITS  = 4;
  localparam int unsigned FRAC_SCALE = 625;
  localparam int unsigned INT_STEPS  = 9;
  localparam int unsigned FRAC_STEPS = 14;
  localparam int unsigned BCD_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_INT,
    ST_FRAC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/adt7420_temp_to_bcd_bcd_add3_shift.sv
// One double-dabble step over N BCD nibbles: add 3 to nibbles >= 5, then shift in bit_i.
module bcd_add3_shift
  import adt7420_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N*BCD_W-1:0] bcd_i,
  input  logic               bit_i,
  output logic [N*BCD_W-1:0] bcd_o
);

  logic [N*BCD_W-1:0] adj;
  logic               unused_msb;

  always_comb begin
    adj = bcd_i;
    for (int unsigned k = 0; k < N; k++) begin
      if (adj[k*BCD_W +: BCD_W] >= BCD_W'(5)) begin
        adj[k*BCD_W +: BCD_W] = adj[k*BCD_W +: BCD_W] + BCD_W'(3);
      end
    end
    {unused_msb, bcd_o} = {adj, bit_i};
  end

endmodule

// File: rtl/adt7420_temp_to_bcd.sv
// Multi-cycle ADT7420 raw word to sign + 3.2 BCD digit converter with valid/ready handshakes.
// Optional half-up rounding of the fraction when ADT7420_BCD_ROUND_EN is defined.
module adt7420_temp_to_bcd #(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned TEMP_BITS = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] temp_raw,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            neg,
  output logic [11:0]     int_bcd,
  output logic [7:0]      frac_bcd
);
  import adt7420_pkg::*;

  localparam int unsigned IP_W  = TEMP_BITS - FRAC_BITS;
  localparam int unsigned FP_W  = FRAC_STEPS;
  localparam int unsigned IBCD_W = 3 * BCD_W;
  localparam int unsigned FBCD_W = 4 * BCD_W;

  state_e                 state_q, state_d;
  logic [TEMP_BITS-1:0]   temp_q, temp_d;
  logic                   sign_q, sign_d;
  logic [IP_W-1:0]        ip_q, ip_d;
  logic [FP_W-1:0]        fp_q, fp_d;
  logic [IBCD_W-1:0]      ibcd_q, ibcd_d;
  logic [FBCD_W-1:0]      fbcd_q, fbcd_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   neg_q, neg_d;
  logic [11:0]            int_q, int_d;
  logic [7:0]             frac_q, frac_d;

  logic [TEMP_BITS-1:0]   mag;
  logic [IBCD_W-1:0]      ibcd_step;
  logic [FBCD_W-1:0]      fbcd_step;
  logic [7:0]             frac_res;
  logic                   unused_bits;

  bcd_add3_shift #(.N(3)) u_int_step (
    .bcd_i (ibcd_q),
    .bit_i (ip_q[IP_W-1]),
    .bcd_o (ibcd_step)
  );

  bcd_add3_shift #(.N(4)) u_frac_step (
    .bcd_i (fbcd_q),
    .bit_i (fp_q[FP_W-1]),
    .bcd_o (fbcd_step)
  );

  // Fraction digits come from the last FRAC step directly, so the result lands on the FRAC->DONE edge.
`ifdef ADT7420_BCD_ROUND_EN
  assign frac_res = {fbcd_step[15:12],
                     fbcd_step[11:8] + ((fbcd_step[7:4] >= 4'd5) ? 4'd1 : 4'd0)};
  assign unused_bits = ^{temp_raw[IN_W-TEMP_BITS-1:0], fbcd_step[3:0]};
`else
  assign frac_res = fbcd_step[15:8];
  assign unused_bits = ^{temp_raw[IN_W-TEMP_BITS-1:0], fbcd_step[7:0]};
`endif

  always_comb begin
    mag = temp_q[TEMP_BITS-1] ? (~temp_q + TEMP_BITS'(1)) : temp_q;
  end

  always_comb begin
    state_d = state_q;
    temp_d  = temp_q;
    sign_d  = sign_q;
    ip_d    = ip_q;
    fp_d    = fp_q;
    ibcd_d  = ibcd_q;
    fbcd_d  = fbcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    int_d   = int_q;
    frac_d  = frac_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          temp_d  = temp_raw[IN_W-1 -: TEMP_BITS];
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        sign_d  = temp_q[TEMP_BITS-1];
        ip_d    = mag[TEMP_BITS-1:FRAC_BITS];
        fp_d    = FP_W'(mag[FRAC_BITS-1:0]) * FP_W'(FRAC_SCALE);
        ibcd_d  = '0;
        fbcd_d  = '0;
        cnt_d   = '0;
        state_d = ST_INT;
      end
      ST_INT: begin
        ibcd_d = ibcd_step;
        ip_d   = {ip_q[IP_W-2:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(INT_STEPS - 1)) begin
          cnt_d   = '0;
          state_d = ST_FRAC;
        end
      end
      ST_FRAC: begin
        fbcd_d = fbcd_step;
        fp_d   = {fp_q[FP_W-2:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(FRAC_STEPS - 1)) begin
          neg_d   = sign_q;
          int_d   = ibcd_q;
          frac_d  = frac_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      temp_q  <= '0;
      sign_q  <= 1'b0;
      ip_q    <= '0;
      fp_q    <= '0;
      ibcd_q  <= '0;
      fbcd_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      sign_q  <= sign_d;
      ip_q    <= ip_d;
      fp_q    <= fp_d;
      ibcd_q  <= ibcd_d;
      fbcd_q  <= fbcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign neg       = neg_q;
  assign int_bcd   = int_q;
  assign frac_bcd  = frac_q;

endmodule
